// File: rtl/seq_detector_param_if.sv
//------------------------------------------------------------------------------
// Module : seq_detector_param_if
// Serial stream in / match flag and hit counter out, for seq_detector_param.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_detector_param_if #(
  parameter int CNT_W = 8
) ();
  logic             en;
  logic             clr;
  logic             x_in;
  logic             y_out;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output en,
    output clr,
    output x_in,
    input  y_out,
    input  hit_cnt
  );

  modport slave (
    input  en,
    input  clr,
    input  x_in,
    output y_out,
    output hit_cnt
  );
endinterface

`default_nettype wire

// File: rtl/seq_detector_param.sv
//------------------------------------------------------------------------------
// Module : seq_detector_param
// Parametrised serial pattern detector with overlap mode and saturating hit
// counter. Define SEQDET_MOORE_EN for a registered (one cycle later) y_out.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detector_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  seq_detector_param_if.slave   io_det
);

  localparam int         C_HW       = LEN - 1;
  localparam logic [4:0] C_FILL_MAX = 5'(LEN - 1);

  // S_ARMED means the history holds LEN-1 genuine bits, so a match may fire.
  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [C_HW-1:0]  r_hist;
  logic [C_HW-1:0]  w_hist_nxt;
  logic [C_HW-1:0]  w_hist_shifted;
  logic [4:0]       r_fill;
  logic [4:0]       w_fill_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_match;

  assign w_accept = io_det.en & ~io_det.clr;
  assign w_match  = w_accept & (r_state == S_ARMED) &
                    ({r_hist, io_det.x_in} == PATTERN);

  generate
    if (LEN > 2) begin : g_hist_shift
      assign w_hist_shifted = {r_hist[C_HW-2:0], io_det.x_in};
    end else begin : g_hist_single
      assign w_hist_shifted = io_det.x_in;
    end
  endgenerate

  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_cnt_nxt  = r_cnt;
    if (io_det.clr) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
      w_cnt_nxt  = '0;
    end else if (io_det.en) begin
      w_hist_nxt = w_hist_shifted;
      if (w_match && !OVERLAP) begin
        w_fill_nxt = '0;
      end else if (r_fill != C_FILL_MAX) begin
        w_fill_nxt = r_fill + 5'd1;
      end
      if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (io_det.clr) begin
      w_state_nxt = S_FILL;
    end else if (io_det.en) begin
      w_state_nxt = (w_fill_nxt == C_FILL_MAX) ? S_ARMED : S_FILL;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_FILL;
      r_hist  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign io_det.hit_cnt = r_cnt;

`ifdef SEQDET_MOORE_EN
  logic r_y;

  // w_match already includes ~clr, so clr forces the flag low here too.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_match;
    end
  end

  assign io_det.y_out = r_y;
`else
  assign io_det.y_out = w_match;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
//------------------------------------------------------------------------------
// Module : tb_seq_detector_param
// Three detector instances (overlap, non-overlap, 2-bit counter) driven in step.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_detector_param;

  localparam int         LEN     = 4;
  localparam logic [3:0] PATTERN = 4'b1011;

  logic clk;
  logic rstn;

  seq_detector_param_if #(.CNT_W(8)) if0 ();
  seq_detector_param_if #(.CNT_W(8)) if1 ();
  seq_detector_param_if #(.CNT_W(2)) if2 ();

  seq_detector_param #(.LEN(LEN), .PATTERN(PATTERN), .OVERLAP(1'b1), .CNT_W(8))
    u_ov  (.clk(clk), .rstn(rstn), .io_det(if0.slave));
  seq_detector_param #(.LEN(LEN), .PATTERN(PATTERN), .OVERLAP(1'b0), .CNT_W(8))
    u_nov (.clk(clk), .rstn(rstn), .io_det(if1.slave));
  seq_detector_param #(.LEN(LEN), .PATTERN(PATTERN), .OVERLAP(1'b1), .CNT_W(2))
    u_sat (.clk(clk), .rstn(rstn), .io_det(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  y;
    logic [23:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: bits accepted since last restart, kept as a number.
  int          nacc [3];
  int unsigned hbits[3];
  int          cnt  [3];
  bit          pm   [3];
  int          ov   [3] = '{1, 0, 1};
  int          cmax [3] = '{255, 255, 3};

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit c, input bit x,
                            output exp_t ex);
    ex = '0;
    for (int k = 0; k < 3; k++) begin
      bit          m;
      int unsigned win;
      if (!r) begin
        nacc[k] = 0; hbits[k] = 0; cnt[k] = 0; pm[k] = 0;
      end else begin
        win = ((hbits[k] << 1) | 32'(x)) & 32'hF;
        m   = e && !c && (nacc[k] >= LEN - 1) && (win == 32'(PATTERN));
`ifdef SEQDET_MOORE_EN
        ex.y[k] = pm[k];
`else
        ex.y[k] = m;
`endif
        ex.c[8*k +: 8] = 8'(cnt[k]);
        if (c) begin
          nacc[k] = 0; hbits[k] = 0; cnt[k] = 0;
        end else if (e) begin
          hbits[k] = win;
          nacc[k]  = (m && ov[k] == 0) ? 0 : nacc[k] + 1;
          if (m && cnt[k] < cmax[k]) cnt[k]++;
        end
        pm[k] = m;
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit c, input bit x);
    exp_t ex;
    @(posedge clk);
    #1;
    rstn = r;
    if0.en = e; if0.clr = c; if0.x_in = x;
    if1.en = e; if1.clr = c; if1.x_in = x;
    if2.en = e; if2.clr = c; if2.x_in = x;
    model_step(r, e, c, x, ex);
    sb.push_back(ex);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, 1'b1, 1'b0, bits[i]);
  endtask

  task automatic do_clr();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  // Idle one cycle so the last accepted bit has reached hit_cnt.
  task automatic settle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  // Monitor: the detector presents y_out/hit_cnt every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("y_out ov",    int'(if0.y_out),   int'(e.y[0]));
        check("y_out nov",   int'(if1.y_out),   int'(e.y[1]));
        check("y_out sat",   int'(if2.y_out),   int'(e.y[2]));
        check("hit_cnt ov",  int'(if0.hit_cnt), int'(e.c[7:0]));
        check("hit_cnt nov", int'(if1.hit_cnt), int'(e.c[15:8]));
        check("hit_cnt sat", int'(if2.hit_cnt), int'(e.c[23:16]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    if0.en = 1'b0; if0.clr = 1'b0; if0.x_in = 1'b0;
    if1.en = 1'b0; if1.clr = 1'b0; if1.x_in = 1'b0;
    if2.en = 1'b0; if2.clr = 1'b0; if2.x_in = 1'b0;

    // Held in reset with the input toggling, then first bits after release.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'(i));
    send_bits(32'b101, 3);
    settle();
    check("cnt after 3 bits", int'(if0.hit_cnt), 0);

    do_clr();
    send_bits(32'b1011011, 7);
    settle();
    check("overlap stream cnt",    int'(if0.hit_cnt), 2);
    check("nonoverlap stream cnt", int'(if1.hit_cnt), 1);

    do_clr();
    send_bits(32'b10, 2);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(32'b11, 2);
    settle();
    check("en gap cnt", int'(if0.hit_cnt), 1);

    do_clr();
    send_bits(32'b101, 3);
    do_clr();
    send_bits(32'b011, 3);
    settle();
    check("after clr no match", int'(if0.hit_cnt), 0);
    send_bits(32'b1011, 4);
    settle();
    check("after clr match", int'(if0.hit_cnt), 1);

    do_clr();
    send_bits(32'b1, 1);
    for (int i = 0; i < 6; i++) send_bits(32'b011, 3);
    settle();
    check("six matches wide cnt", int'(if0.hit_cnt), 6);
    check("saturated cnt",        int'(if2.hit_cnt), 3);

    // Reset mid-pattern must discard the partial match.
    do_clr();
    send_bits(32'b101, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    send_bits(32'b1, 1);
    settle();
    check("cnt after midstream reset", int'(if0.hit_cnt), 0);

    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 80),
            ($urandom_range(0, 99) < 4),
            1'($urandom));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
